// File: rtl/riscv_data_mem.sv
// ---------------------------------------------------------------------------
// riscv_data_mem
//
// Stallable, handshaked data memory for the single-cycle RISC-V core. One
// load or store is accepted at a time. The request then waits a fixed number
// of cycles and completes with a one-cycle `ready` pulse. Accesses are byte,
// half or word wide against a word-organised RAM. Load data is sign- or
// zero-extended. Misaligned accesses and unknown funct3 codes are reported
// on `fault` and have no side effects.
//
// Parameters
//   DEPTH_WORDS : RAM depth in 32-bit words (power of two, >= 4)
//   WAIT_STATES : extra cycles between accept and response (0..7)
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   asynchronous, active-low reset
//   req     in   request strobe, sampled only while idle
//   we      in   1 = store, 0 = load
//   funct3  in   RISC-V width/sign code
//   addr    in   byte address; bits above the RAM range are ignored
//   wdata   in   store data; low byte/half used for SB/SH
//   ready   out  one-cycle response pulse
//   rdata   out  extended load data, held until the next response
//   fault   out  misaligned/illegal flag, valid with ready and held
//   busy    out  high from the cycle after accept through the ready cycle
//
// Timing: a request sampled at edge N completes on edge N+WAIT_STATES+1,
// so `ready` is high in the cycle that follows that edge. `ready` is only
// high while the FSM is back in IDLE. This lets a `req` that is held high
// be accepted on the very next edge with no lost cycle.
// Stores and faulted requests return rdata = 0.
// ---------------------------------------------------------------------------
module riscv_data_mem #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // The counter is only loaded when there is at least one wait state.
  // Clamp the initial value so the zero-wait build still elaborates cleanly.
  localparam int         CNT_INIT_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [2:0] CNT_INIT   = CNT_INIT_I[2:0];

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // State and captured request
  // -------------------------------------------------------------------------
  state_t         state_reg;
  logic [2:0]     cnt_reg;
  logic           req_we_reg;
  logic [2:0]     req_funct3_reg;
  logic [AW+1:0]  req_addr_reg;
  logic [31:0]    req_wdata_reg;

  logic           ready_reg;
  logic [31:0]    rdata_reg;
  logic           fault_reg;
  logic           busy_reg;

  // Address bits above the RAM range never matter; addresses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:AW+2];

  logic [1:0]    req_off;
  logic [AW-1:0] req_idx;
  assign req_off = req_addr_reg[1:0];
  assign req_idx = req_addr_reg[AW+1:2];

  // -------------------------------------------------------------------------
  // Legality of the captured request
  // -------------------------------------------------------------------------
  logic req_fault;

  always_comb begin
    req_fault = 1'b0;
    if (req_we_reg) begin
      case (req_funct3_reg)
        F3_B:    req_fault = 1'b0;
        F3_H:    req_fault = req_off[0];
        F3_W:    req_fault = |req_off;
        default: req_fault = 1'b1;
      endcase
    end else begin
      case (req_funct3_reg)
        F3_B, F3_BU: req_fault = 1'b0;
        F3_H, F3_HU: req_fault = req_off[0];
        F3_W:        req_fault = |req_off;
        default:     req_fault = 1'b1;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Store byte lanes: enable and data per lane of the RAM word.
  // SB replicates the low byte and SH replicates the low half across the
  // word. The enables pick out the lane or lanes that are actually written.
  // -------------------------------------------------------------------------
  logic [3:0] byte_en;
  logic [7:0] wr_lane [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      localparam int         HOFF = (gi % 2) * 8;

      assign byte_en[gi] =
          (req_funct3_reg[1:0] == 2'b10) ||
          ((req_funct3_reg[1:0] == 2'b01) && (req_off[1] == LANE[1])) ||
          ((req_funct3_reg[1:0] == 2'b00) && (req_off == LANE));

      assign wr_lane[gi] =
          (req_funct3_reg[1:0] == 2'b10) ? req_wdata_reg[8*gi +: 8] :
          (req_funct3_reg[1:0] == 2'b01) ? req_wdata_reg[HOFF +: 8] :
                                           req_wdata_reg[7:0];
    end
  endgenerate

  logic wr_en;
  assign wr_en = (state_reg == S_RESP) && req_we_reg && !req_fault;

  // -------------------------------------------------------------------------
  // Word RAM with a registered read port.
  // While idle, the read address follows the live `addr` input. This means
  // the word is already in ram_q when the zero-wait build reaches its
  // response edge. After accept, the address follows the captured request.
  // Writes only happen on a response edge. The next accept is at least one
  // edge later, so a following load always reads the updated word.
  // -------------------------------------------------------------------------
  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   ram_q;
  logic [AW-1:0] rd_idx;

  assign rd_idx = (state_reg == S_IDLE) ? addr[AW+1:2] : req_idx;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en && byte_en[b]) begin
        mem[req_idx][8*b +: 8] <= wr_lane[b];
      end
    end
    ram_q <= mem[rd_idx];
  end

  // -------------------------------------------------------------------------
  // Load extraction and extension
  // -------------------------------------------------------------------------
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    ld_byte = ram_q[7:0];
    case (req_off)
      2'd0:    ld_byte = ram_q[7:0];
      2'd1:    ld_byte = ram_q[15:8];
      2'd2:    ld_byte = ram_q[23:16];
      default: ld_byte = ram_q[31:24];
    endcase
    ld_half = req_off[1] ? ram_q[31:16] : ram_q[15:0];

    ld_data = 32'd0;
    case (req_funct3_reg)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_W:    ld_data = ram_q;
      F3_BU:   ld_data = {24'd0, ld_byte};
      F3_HU:   ld_data = {16'd0, ld_half};
      default: ld_data = 32'd0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Control FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= 3'd0;
      req_we_reg     <= 1'b0;
      req_funct3_reg <= 3'd0;
      req_addr_reg   <= '0;
      req_wdata_reg  <= 32'd0;
      ready_reg      <= 1'b0;
      rdata_reg      <= 32'd0;
      fault_reg      <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      ready_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          busy_reg <= req;
          if (req) begin
            req_we_reg     <= we;
            req_funct3_reg <= funct3;
            req_addr_reg   <= addr[AW+1:0];
            req_wdata_reg  <= wdata;
            cnt_reg        <= CNT_INIT;
            state_reg      <= (WAIT_STATES > 0) ? S_WAIT : S_RESP;
          end
        end

        S_WAIT: begin
          if (cnt_reg == 3'd0) begin
            state_reg <= S_RESP;
          end else begin
            cnt_reg <= cnt_reg - 3'd1;
          end
        end

        S_RESP: begin
          // The RAM write for a legal store happens on this same edge.
          ready_reg <= 1'b1;
          fault_reg <= req_fault;
          rdata_reg <= (req_fault || req_we_reg) ? 32'd0 : ld_data;
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign ready = ready_reg;
  assign rdata = rdata_reg;
  assign fault = fault_reg;
  assign busy  = busy_reg;

endmodule

// File: tb/tb_riscv_data_mem.sv
// ---------------------------------------------------------------------------
// tb_riscv_data_mem
//
// Three DUT instances share one clock:
//   inst0 WAIT_STATES=1
//   inst1 WAIT_STATES=0
//   inst2 WAIT_STATES=3
// Each instance has its own inputs and reset.
//
// A behavioural model per instance keeps a byte-addressed memory image. It
// applies the accept/latency/throughput rules as plain edge arithmetic.
// A single compare process checks every DUT output against that model on
// each falling edge. Directed transactions also carry hand-computed
// literal expectations.
// ---------------------------------------------------------------------------
module tb_riscv_data_mem;

  localparam int N    = 3;
  localparam int MEMB = 4096;   // bytes in a 1024-word RAM

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [N];
  logic        req [N];
  logic        we  [N];
  logic [2:0]  f3  [N];
  logic [31:0] ad  [N];
  logic [31:0] wd  [N];
  logic        rdy [N];
  logic [31:0] rd  [N];
  logic        flt [N];
  logic        bsy [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_dut
      riscv_data_mem #(
        .DEPTH_WORDS(1024),
        .WAIT_STATES(gi == 0 ? 1 : (gi == 1 ? 0 : 3))
      ) u_dut (
        .clk   (clk),
        .reset (rst[gi]),
        .req   (req[gi]),
        .we    (we[gi]),
        .funct3(f3[gi]),
        .addr  (ad[gi]),
        .wdata (wd[gi]),
        .ready (rdy[gi]),
        .rdata (rd[gi]),
        .fault (flt[gi]),
        .busy  (bsy[gi])
      );
    end
  endgenerate

  function automatic int ws_of(int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
  endfunction

  int n_cmp  = 0;
  int n_bad  = 0;
  int ecount = 0;   // number of rising edges seen so far

  task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d t=%0t: got %h, want %h", name, i, $time, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model
  // -------------------------------------------------------------------------
  logic [7:0]  mm    [N][MEMB];
  int          m_acc [N] = '{-1, -1, -1};   // edge at which the request was accepted
  int          m_resp[N] = '{-1, -1, -1};   // edge of the latest response
  logic        m_we  [N];
  logic [2:0]  m_f3  [N];
  logic [31:0] m_ad  [N];
  logic [31:0] m_wd  [N];
  logic [31:0] m_rd  [N];
  logic        m_flt [N];
  logic        m_rdk [N];   // rdata is defined (after load, fault or reset)

  task automatic model_respond(int i);
    int         a;
    int         size;
    bit         ok;
    logic [63:0] v;
    a    = int'(m_ad[i] % MEMB);
    size = (m_f3[i][1:0] == 2'b00) ? 1 : ((m_f3[i][1:0] == 2'b01) ? 2 : 4);
    if (m_we[i]) ok = (m_f3[i] inside {3'b000, 3'b001, 3'b010});
    else         ok = (m_f3[i] inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    if (a % size != 0) ok = 1'b0;
    m_flt[i] = !ok;
    if (!ok) begin
      m_rd[i]  = 32'd0;
      m_rdk[i] = 1'b1;
    end else if (m_we[i]) begin
      for (int k = 0; k < size; k++) mm[i][a+k] = m_wd[i][8*k +: 8];
      m_rdk[i] = 1'b0;
    end else begin
      v = 64'd0;
      for (int k = 0; k < size; k++) v = v | (64'(mm[i][a+k]) << (8*k));
      if (!m_f3[i][2] && size < 4 && v[8*size-1])
        v = v | ~((64'd1 << (8*size)) - 64'd1);
      m_rd[i]  = v[31:0];
      m_rdk[i] = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    ecount++;
    for (int i = 0; i < N; i++) begin
      if (!rst[i]) begin
        m_acc[i]  = -1;
        m_resp[i] = -1;
        m_rd[i]   = 32'd0;
        m_flt[i]  = 1'b0;
        m_rdk[i]  = 1'b1;
      end else if (m_acc[i] >= 0 && ecount == m_acc[i] + ws_of(i) + 1) begin
        model_respond(i);
        m_resp[i] = ecount;
      end else if ((m_acc[i] < 0 || ecount > m_acc[i] + ws_of(i) + 1) && req[i]) begin
        m_we[i]  = we[i];
        m_f3[i]  = f3[i];
        m_ad[i]  = ad[i];
        m_wd[i]  = wd[i];
        m_acc[i] = ecount;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      chk("ready", i, 32'(rdy[i]), 32'(m_resp[i] == ecount));
      chk("busy", i, 32'(bsy[i]),
          32'(m_acc[i] >= 0 && ecount >= m_acc[i] && ecount <= m_acc[i] + ws_of(i) + 1));
      chk("fault", i, 32'(flt[i]), 32'(m_flt[i]));
      if (m_rdk[i]) chk("rdata", i, rd[i], m_rd[i]);
    end
  end

  // -------------------------------------------------------------------------
  // Directed transaction with literal expectations
  // -------------------------------------------------------------------------
  task automatic xact(int i, logic w, logic [2:0] f, logic [31:0] a, logic [31:0] d,
                      logic [31:0] exp_rd, logic exp_f, bit chk_rd, int exp_lat);
    int start;
    int lat;
    bit seen;
    @(negedge clk);
    #1;
    req[i] = 1'b1; we[i] = w; f3[i] = f; ad[i] = a; wd[i] = d;
    start = ecount;
    seen  = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (rdy[i]) seen = 1'b1;
    end
    lat = ecount - (start + 1);
    chk("ready_seen", i, 32'(seen), 32'd1);
    chk("latency", i, lat, exp_lat);
    chk("fault_lit", i, 32'(flt[i]), 32'(exp_f));
    if (chk_rd) chk("rdata_lit", i, rd[i], exp_rd);
    $display("xact inst%0d we=%0d f3=%03b addr=%h wdata=%h -> rdata=%h fault=%0d lat=%0d",
             i, w, f, a, d, rd[i], flt[i], lat);
    #1 req[i] = 1'b0;
  endtask

  initial begin
    int  prev;
    bit  seen;

    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; we[i] = 1'b0;
      f3[i] = 3'd0; ad[i] = 32'd0; wd[i] = 32'd0;
    end
    #1;
    for (int i = 0; i < N; i++) rst[i] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk("rst_ready", i, 32'(rdy[i]), 32'd0);
      chk("rst_rdata", i, rd[i], 32'd0);
      chk("rst_fault", i, 32'(flt[i]), 32'd0);
      chk("rst_busy", i, 32'(bsy[i]), 32'd0);
    end
    #1;
    for (int i = 0; i < N; i++) rst[i] = 1'b1;

    // ---- inst0, one wait state: word, sub-word and fault cases ----
    xact(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 2);
    xact(0, 1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1, 2);
    xact(0, 1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, 1'b1, 2);
    xact(0, 1'b0, 3'b100, 32'h13, 32'h0,        32'h000000DE, 1'b0, 1'b1, 2);
    xact(0, 1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 1'b0, 1'b1, 2);
    xact(0, 1'b0, 3'b101, 32'h10, 32'h0,        32'h0000BEEF, 1'b0, 1'b1, 2);
    xact(0, 1'b1, 3'b000, 32'h11, 32'h77777755, 32'h0,        1'b0, 1'b0, 2);
    xact(0, 1'b0, 3'b010, 32'h10, 32'h0,        32'hDEAD55EF, 1'b0, 1'b1, 2);
    xact(0, 1'b1, 3'b001, 32'h12, 32'h99991234, 32'h0,        1'b0, 1'b0, 2);
    xact(0, 1'b0, 3'b010, 32'h10, 32'h0,        32'h123455EF, 1'b0, 1'b1, 2);
    xact(0, 1'b0, 3'b010, 32'h12, 32'h0,        32'h0,        1'b1, 1'b1, 2);
    xact(0, 1'b1, 3'b001, 32'h11, 32'h0000FFFF, 32'h0,        1'b1, 1'b1, 2);
    xact(0, 1'b0, 3'b010, 32'h10, 32'h0,        32'h123455EF, 1'b0, 1'b1, 2);
    xact(0, 1'b0, 3'b011, 32'h10, 32'h0,        32'h0,        1'b1, 1'b1, 2);
    xact(0, 1'b1, 3'b100, 32'h10, 32'h0,        32'h0,        1'b1, 1'b1, 2);
    xact(0, 1'b0, 3'b010, 32'h10, 32'h0,        32'h123455EF, 1'b0, 1'b1, 2);

    // ---- inst1, zero wait states: back-to-back loads and address wrap ----
    for (int k = 0; k < 4; k++)
      xact(1, 1'b1, 3'b010, 32'h100 + 32'(4*k), 32'h11110000 + 32'(k), 32'h0, 1'b0, 1'b0, 1);
    @(negedge clk);
    #1;
    req[1] = 1'b1; we[1] = 1'b0; f3[1] = 3'b010; ad[1] = 32'h100;
    prev = -1;
    for (int k = 0; k < 4; k++) begin
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        if (rdy[1]) seen = 1'b1;
      end
      chk("b2b_seen", 1, 32'(seen), 32'd1);
      chk("b2b_rdata", 1, rd[1], 32'h11110000 + 32'(k));
      if (k > 0) chk("b2b_gap", 1, ecount - prev, 32'd2);
      $display("b2b inst1 load %0d addr=%h -> rdata=%h edge=%0d", k, ad[1], rd[1], ecount);
      prev = ecount;
      #1;
      if (k < 3) ad[1] = 32'h100 + 32'(4*(k+1));
      else       req[1] = 1'b0;
    end
    xact(1, 1'b1, 3'b010, 32'h1000, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0, 1);
    xact(1, 1'b0, 3'b010, 32'h0,    32'h0,        32'hCAFEF00D, 1'b0, 1'b1, 1);

    // ---- inst2, three wait states: reset during a pending store ----
    xact(2, 1'b1, 3'b010, 32'h20, 32'h11111111, 32'h0,        1'b0, 1'b0, 4);
    xact(2, 1'b0, 3'b010, 32'h20, 32'h0,        32'h11111111, 1'b0, 1'b1, 4);
    @(negedge clk);
    #1;
    req[2] = 1'b1; we[2] = 1'b1; f3[2] = 3'b010; ad[2] = 32'h20; wd[2] = 32'hAAAAAAAA;
    repeat (2) @(negedge clk);
    chk("mid_busy", 2, 32'(bsy[2]), 32'd1);
    #1;
    rst[2] = 1'b0;
    req[2] = 1'b0;
    #1;
    chk("abort_ready", 2, 32'(rdy[2]), 32'd0);
    chk("abort_rdata", 2, rd[2], 32'd0);
    chk("abort_fault", 2, 32'(flt[2]), 32'd0);
    chk("abort_busy", 2, 32'(bsy[2]), 32'd0);
    $display("reset inst2 asserted mid-store: ready=%0d rdata=%h fault=%0d busy=%0d",
             rdy[2], rd[2], flt[2], bsy[2]);
    repeat (2) @(negedge clk);
    #1 rst[2] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("no_ready", 2, 32'(rdy[2]), 32'd0);
    end
    xact(2, 1'b0, 3'b010, 32'h20, 32'h0, 32'h11111111, 1'b0, 1'b1, 4);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
